queue_arbiter: RTL and testbench

Shares one `queue` FIFO instance between NUM_REQ producers and drains it into a single registered valid/ready output. The write side is a round-robin arbiter with a per-tenure burst quota. The read side is a one-entry output register that pops the queue whenever the register is free or being consumed. The block sits between the producer clients and the FIFO on one side, and between the FIFO and the downstream consumer on the other.

---
 rtl/queue_arbiter.sv | 129 ++++++++++++
 tb/tb_queue_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/queue_arbiter.sv
// queue_arbiter
//   Shares one external FIFO ("queue") between NUM_REQ producers and drains it
//   into a single registered valid/ready output.
//   Write side: round-robin arbiter with a per-tenure burst quota (BURST).
//   Read side : one-entry output register that pops the queue whenever the
//               register is empty or being consumed this cycle.
// Ports
//   clk, rst             clock, synchronous active-high reset (shared with queue)
//   req, req_data        producer requests and their words (slice i*SIZE +: SIZE)
//   gnt                  combinational one-hot/zero grant; accept = req[i] & gnt[i]
//   q_wr, q_wr_data      queue write strobe and granted word (0 when idle)
//   q_full, q_empty      queue status flags
//   q_rd, q_rd_data      queue pop strobe and combinational head word
//   out_valid, out_data  output register
//   out_ready            consumer accepts out_data this cycle
//   owner                current tenure holder, for debug
module queue_arbiter #(
    parameter int SIZE    = 16,
    parameter int NUM_REQ = 4,
    parameter int BURST   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*SIZE-1:0]    req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       q_wr,
    output logic [SIZE-1:0]            q_wr_data,
    input  logic                       q_full,
    input  logic                       q_empty,
    output logic                       q_rd,
    input  logic [SIZE-1:0]            q_rd_data,
    output logic                       out_valid,
    output logic [SIZE-1:0]            out_data,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST + 1);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic            out_valid_q, out_valid_d;
    logic [SIZE-1:0] out_data_q, out_data_d;

    logic [PW-1:0]   idx;
    logic            found;
    logic            pop;

    // ------------------------------------------------------------------
    // Arbiter: keep the tenure while the owner requests and has quota left,
    // otherwise search from ptr+1 and wrap around to ptr itself, so a sole
    // requester with an exhausted quota is regranted without a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        gnt    = '0;
        ptr_d  = ptr_q;
        bcnt_d = bcnt_q;
        idx    = '0;
        found  = 1'b0;
        if (!q_full) begin
            if (req[ptr_q] && (bcnt_q < CW'(BURST))) begin
                gnt[ptr_q] = 1'b1;
                bcnt_d     = bcnt_q + CW'(1);
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = PW'((int'(ptr_q) + k) % NUM_REQ);
                    if (!found && req[idx]) begin
                        found    = 1'b1;
                        gnt[idx] = 1'b1;
                        ptr_d    = idx;
                        bcnt_d   = CW'(1);
                    end
                end
            end
        end
    end

    // gnt is one-hot or zero, so an AND-OR mux yields 0 when nothing is granted.
    always_comb begin
        q_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                q_wr_data = q_wr_data | req_data[i*SIZE +: SIZE];
            end
        end
    end

    assign q_wr  = |gnt;
    assign owner = ptr_q;

    // ------------------------------------------------------------------
    // Drain: pop whenever the output register is free or being consumed.
    // ------------------------------------------------------------------
    assign pop  = ~q_empty & (~out_valid_q | out_ready);
    assign q_rd = pop;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = q_rd_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Reset leaves the quota exhausted on the last index so the first
    // rotation after reset starts searching at producer 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= PW'(NUM_REQ - 1);
            bcnt_q      <= CW'(BURST);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            bcnt_q      <= bcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_queue_arbiter.sv
module tb_queue_arbiter;
    localparam int W = 16, N = 4, B = 2, DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic           q_wr;
    logic [W-1:0]   q_wr_data;
    logic           q_full = 1'b0;
    logic           q_empty = 1'b1;
    logic           q_rd;
    logic [W-1:0]   q_rd_data = '0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready = 1'b0;
    logic [1:0]     owner;

    queue_arbiter #(.SIZE(W), .NUM_REQ(N), .BURST(B)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .q_wr(q_wr), .q_wr_data(q_wr_data), .q_full(q_full), .q_empty(q_empty),
        .q_rd(q_rd), .q_rd_data(q_rd_data), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .owner(owner)
    );

    always #5 clk = ~clk;

    // Reference model: arbiter pointer/quota as integers, the attached queue
    // and the output register as a word queue plus a valid/data pair.
    int           m_ptr = N - 1, m_bcnt = B;
    bit           m_ov = 1'b0;
    logic [W-1:0] m_od = '0;
    logic [W-1:0] fifo[$];
    logic [N-1:0] m_gnt;
    int           m_nptr, m_nbcnt;
    bit           m_rd;
    logic [W-1:0] m_wd;

    int n_pass = 0, n_tot = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Predict this cycle's combinational outputs and compare at the falling edge.
    task automatic sample();
        @(negedge clk);
        m_gnt = '0; m_nptr = m_ptr; m_nbcnt = m_bcnt; m_wd = '0;
        if (!q_full) begin
            if (req[m_ptr] && m_bcnt < B) begin
                m_gnt[m_ptr] = 1'b1;
                m_nbcnt = m_bcnt + 1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int i = (m_ptr + k) % N;
                    if (req[i]) begin
                        m_gnt[i] = 1'b1; m_nptr = i; m_nbcnt = 1;
                        break;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) if (m_gnt[i]) m_wd = req_data[i*W +: W];
        m_rd = (fifo.size() != 0) && (!m_ov || out_ready);
        check("gnt", gnt, m_gnt);
        check("q_wr", q_wr, |m_gnt);
        check("q_wr_data", q_wr_data, m_wd);
        check("q_rd", q_rd, m_rd);
        check("out_valid", out_valid, m_ov);
        check("out_data", out_data, m_od);
        check("owner", owner, m_ptr);
    endtask

    // Clock edge: advance the model and the queue fixture, then drive queue flags.
    task automatic advance();
        @(posedge clk);
        #1;
        if (rst) begin
            m_ptr = N - 1; m_bcnt = B; m_ov = 1'b0; m_od = '0;
            fifo.delete();
        end else begin
            if (m_gnt != 0) begin m_ptr = m_nptr; m_bcnt = m_nbcnt; end
            if (m_rd) begin m_od = fifo.pop_front(); m_ov = 1'b1; end
            else if (out_ready) m_ov = 1'b0;
            if (m_gnt != 0) fifo.push_back(m_wd);
        end
        q_full  = (fifo.size() == DEPTH);
        q_empty = (fifo.size() == 0);
        q_rd_data = '0;
        if (fifo.size() != 0) q_rd_data = fifo[0];
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic [N-1:0] gnt;
        logic [1:0]   own;
        logic         ov;
        logic [W-1:0] od;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[20];
        bit           pend[N];
        logic [W-1:0] pdat[N];
        int           ngr;

        // Idle after reset, then all four requesting, then only producer 2.
        // Data of producer i is i.
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 16'd0};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 16'd0};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 16'd0};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 16'd0};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 16'd0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 2'd3, 1'b0, 16'd0};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, 16'd0};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0010, 2'd0, 1'b1, 16'd0};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 16'd0};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0100, 2'd1, 1'b1, 16'd1};
        tbl[10] = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 16'd1};
        tbl[11] = '{4'b1111, 1'b1, 4'b1000, 2'd2, 1'b1, 16'd2};
        tbl[12] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 16'd2};
        tbl[13] = '{4'b1111, 1'b1, 4'b0001, 2'd3, 1'b1, 16'd3};
        tbl[14] = '{4'b0100, 1'b1, 4'b0100, 2'd0, 1'b1, 16'd3};
        tbl[15] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 16'd0};
        tbl[16] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 16'd2};
        tbl[17] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 16'd2};
        tbl[18] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 16'd2};
        tbl[19] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 16'd2};

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_data = {16'd3, 16'd2, 16'd1, 16'd0};
        for (int r = 0; r < 20; r++) begin
            req = tbl[r].req;
            out_ready = tbl[r].rdy;
            sample();
            check($sformatf("tbl%0d_gnt", r), gnt, tbl[r].gnt);
            check($sformatf("tbl%0d_owner", r), owner, tbl[r].own);
            check($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].ov);
            check($sformatf("tbl%0d_out_data", r), out_data, tbl[r].od);
            advance();
        end

        // Producer 1 drops after its first grant: rotation to 2 with no bubble,
        // and 2 starts a fresh quota (one more continue, then rotate back to 1).
        req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        req = 4'b0110; sample(); check("drop_g1", gnt, 4'b0010); advance();
        req = 4'b0100; sample(); check("drop_g2", gnt, 4'b0100); advance();
        req = 4'b0110; sample(); check("drop_cont", gnt, 4'b0100);
        check("drop_owner", owner, 2); advance();
        sample(); check("drop_rot", gnt, 4'b0010); advance();

        // Drain everything.
        req = '0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample(); advance();
            if (q_empty && !m_ov) break;
        end

        // Fill: consumer stalled, 8 queue entries + 1 output register.
        req = 4'b1111; out_ready = 1'b0; ngr = 0;
        for (int i = 0; i < 40 && !q_full; i++) begin
            sample();
            if (q_wr) ngr++;
            advance();
        end
        check("full_reached", q_full, 1'b1);
        check("fill_grants", ngr, 9);
        sample(); check("full_gnt0", gnt, 4'b0000); advance();
        out_ready = 1'b1;
        sample(); check("full_pop_gnt0", gnt, 4'b0000); check("full_pop_rd", q_rd, 1'b1); advance();
        sample(); check("resume_wr", q_wr, 1'b1); advance();

        // Reset mid-stream with words queued and the output register occupied.
        for (int i = 0; i < 3; i++) begin sample(); advance(); end
        out_ready = 1'b0;
        sample(); check("pre_rst_ov", out_valid, 1'b1); advance();
        rst = 1'b1;
        sample(); advance();
        rst = 1'b0;
        sample();
        check("post_rst_ov", out_valid, 1'b0);
        check("post_rst_owner", owner, 3);
        check("post_rst_gnt", gnt, 4'b0001);
        advance();

        // Randomized traffic: producers hold word until granted; consumer
        // mostly stalled at first (to hit full), then mostly ready.
        req = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pdat[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pdat[i] = W'($urandom);
                end
                req[i] = pend[i];
                req_data[i*W +: W] = pdat[i];
            end
            out_ready = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            sample();
            advance();
            for (int i = 0; i < N; i++) if (m_gnt[i]) pend[i] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
